// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
//   state_t      : receive FSM state encoding
//   PREFIX_EXT   : scan-code prefix for extended keys
//   PREFIX_BREAK : scan-code prefix for key release
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [7:0] PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PREFIX_BREAK = 8'hF0;

  // Odd parity over data byte plus parity bit: a good frame has an odd ones count.
  function automatic logic odd_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Bundle of PS/2 pad inputs and decoded scan-code outputs.
//   ps2_clk, ps2_data : raw pad signals (asynchronous to clk)
//   code              : last accepted scan code
//   code_valid        : one-cycle pulse, code/code_break/code_ext valid
//   code_break        : code was preceded by a release prefix
//   code_ext          : code was preceded by an extended prefix
//   frame_err         : one-cycle pulse on a malformed or timed-out frame
// slave  : the receiver (consumes pads, drives results)
// master : the pad side / downstream consumer
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       code_break;
  logic       code_ext;
  logic       frame_err;

  modport slave (
    input  ps2_clk, ps2_data,
    output code, code_valid, code_break, code_ext, frame_err
  );

  modport master (
    output ps2_clk, ps2_data,
    input  code, code_valid, code_break, code_ext, frame_err
  );
endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a debounce filter. The output level only
// changes after FILTER_LEN consecutive synchronized samples disagree with it.
// Everything resets to 1, the idle level of the PS/2 bus.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_raw      : raw asynchronous pad input
//   o_level    : filtered, synchronous level
module ps2_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int unsigned CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // r_cnt counts disagreeing samples already seen; the FILTER_LEN-th one flips the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver and scan-code prefix decoder.
// Receives start/8 data (LSB first)/odd parity/stop frames on filtered falling
// edges of ps2_clk, folds E0/F0 prefixes into flags, and reports each other
// byte as a one-cycle code_valid pulse. No ASCII translation is done here.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : ps2_rx_if.slave (pads in, code/flags/pulses out)
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic      clk,
  input  logic      rst_n,
  ps2_rx_if.slave   bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  // Pad conditioning
  logic w_clk_filt;
  logic r_clk_filt_d;
  logic r_data_s1;
  logic r_data_s2;
  logic w_fall;
  logic w_data_s;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (bus.ps2_clk),
    .o_level (w_clk_filt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_s1    <= 1'b1;
      r_data_s2    <= 1'b1;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_data_s1    <= bus.ps2_data;
      r_data_s2    <= r_data_s1;
      r_clk_filt_d <= w_clk_filt;
    end
  end

  assign w_data_s = r_data_s2;
  assign w_fall   = r_clk_filt_d & ~w_clk_filt;

  // FSM and datapath state
  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo_cnt;
  logic          w_timeout;

  // FSM outputs
  logic w_bit_clr;
  logic w_shift_en;
  logic w_par_en;
  logic w_frame_end;
  logic w_good;
  logic w_bad;

  // Result registers
  logic       r_ext;
  logic       r_break;
  logic [7:0] r_code;
  logic       r_code_valid;
  logic       r_code_break;
  logic       r_code_ext;
  logic       r_frame_err;

  // An edge in the same cycle as the expiry wins, so the frame keeps going.
  assign w_timeout = (r_state != ST_IDLE) && !w_fall &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_fall && !w_data_s)            w_next = ST_DATA;
      ST_DATA:   if (w_fall && (r_bit_cnt == 3'd7))  w_next = ST_PARITY;
      ST_PARITY: if (w_fall)                         w_next = ST_STOP;
      ST_STOP:   if (w_fall)                         w_next = ST_IDLE;
      default:                                       w_next = ST_IDLE;
    endcase
    if (w_timeout) w_next = ST_IDLE;
  end

  always_comb begin
    w_bit_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_frame_end = 1'b0;
    unique case (r_state)
      ST_IDLE:   w_bit_clr   = w_fall && !w_data_s;
      ST_DATA:   w_shift_en  = w_fall;
      ST_PARITY: w_par_en    = w_fall;
      ST_STOP:   w_frame_end = w_fall;
      default:   ;
    endcase
  end

  assign w_good = w_frame_end &  (w_data_s & odd_ok(r_shift, r_parity));
  assign w_bad  = (w_frame_end & ~(w_data_s & odd_ok(r_shift, r_parity))) | w_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_shift_en) r_shift  <= {w_data_s, r_shift[7:1]};
      if (w_par_en)   r_parity <= w_data_s;

      if ((r_state == ST_IDLE) || w_fall) r_tmo_cnt <= '0;
      else                                r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  // Prefix bytes only update flags; any other good byte is published with the
  // accumulated flags, which then clear. Errors clear flags but keep the code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext        <= 1'b0;
      r_break      <= 1'b0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_code_break <= 1'b0;
      r_code_ext   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= w_bad;
      if (w_good) begin
        if (r_shift == PREFIX_EXT) begin
          r_ext <= 1'b1;
        end else if (r_shift == PREFIX_BREAK) begin
          r_break <= 1'b1;
        end else begin
          r_code       <= r_shift;
          r_code_break <= r_break;
          r_code_ext   <= r_ext;
          r_code_valid <= 1'b1;
          r_ext        <= 1'b0;
          r_break      <= 1'b0;
        end
      end else if (w_bad) begin
        r_ext   <= 1'b0;
        r_break <= 1'b0;
      end
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.code_break = r_code_break;
  assign bus.code_ext   = r_code_ext;
  assign bus.frame_err  = r_frame_err;

endmodule
